pc_unit: RTL and testbench

Parametrised program counter for the MIPS fetch stage and successor to the single-target pc block. Holds the current fetch address and advances it by STEP each cycle. Supports branch/jump redirect (hit/data), pipeline stall, and call/return through an internal return-address stack (RAS). Output result drives the instruction memory address.

---
 rtl/pc_unit.sv | 157 +++++++++++++++
 tb/tb_pc_unit.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// Fetch-stage program counter with redirect, stall and a circular return-address stack.
// Optional PC_ALIGN_CHECK_EN adds target alignment with a registered misalign pulse.
module pc_unit #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VEC = '0,
    parameter int               STEP      = 4,
    parameter int               RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             hit,
    input  logic [WIDTH-1:0] data,
    input  logic             call,
    input  logic             ret,
    output logic [WIDTH-1:0] result,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             ras_ovf,
`ifdef PC_ALIGN_CHECK_EN
    output logic             ras_unf,
    output logic             misalign
`else
    output logic             ras_unf
`endif
);

    localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(RAS_DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(RAS_DEPTH);
    localparam logic [WIDTH-1:0] STEP_W    = WIDTH'(STEP);
    localparam logic [WIDTH-1:0] LOW_MASK  = WIDTH'(STEP - 1);

    logic [WIDTH-1:0] r_pc;
    logic [PTR_W-1:0] r_top;
    logic [CNT_W-1:0] r_count;
    logic             r_ovf;
    logic             r_unf;
    logic [WIDTH-1:0] r_stack [RAS_DEPTH];

    logic [WIDTH-1:0] w_seq;
    logic [PTR_W-1:0] w_ptr_inc;
    logic [PTR_W-1:0] w_ptr_dec;
    logic             w_empty;
    logic             w_full;
    logic [WIDTH-1:0] w_target_raw;
    logic [WIDTH-1:0] w_target;
    logic             w_target_misaligned;
    logic [WIDTH-1:0] w_pc_next;
    logic [PTR_W-1:0] w_top_next;
    logic [CNT_W-1:0] w_count_next;
    logic             w_push;
    logic             w_load_target;
    logic             w_ovf_next;
    logic             w_unf_next;

    assign w_seq     = r_pc + STEP_W;
    assign w_ptr_inc = (r_top == LAST_PTR) ? '0 : r_top + PTR_W'(1);
    assign w_ptr_dec = (r_top == '0) ? LAST_PTR : r_top - PTR_W'(1);
    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == FULL_CNT);

    // A pop only supplies the target when ret is not overridden by call.
    assign w_target_raw        = (ret && !call) ? r_stack[r_top] : data;
    assign w_target_misaligned = |(w_target_raw & LOW_MASK);
`ifdef PC_ALIGN_CHECK_EN
    assign w_target = w_target_raw & ~LOW_MASK;
`else
    assign w_target = w_target_raw;
`endif

    always_comb begin
        w_pc_next     = r_pc;
        w_top_next    = r_top;
        w_count_next  = r_count;
        w_push        = 1'b0;
        w_load_target = 1'b0;
        w_ovf_next    = 1'b0;
        w_unf_next    = 1'b0;
        if (!stall) begin
            if (call) begin
                // A full stack overwrites its oldest slot, which is the one after top.
                w_push        = 1'b1;
                w_load_target = 1'b1;
                w_top_next    = w_ptr_inc;
                if (w_full) begin
                    w_ovf_next = 1'b1;
                end else begin
                    w_count_next = r_count + CNT_W'(1);
                end
            end else if (ret) begin
                if (!w_empty) begin
                    w_load_target = 1'b1;
                    w_top_next    = w_ptr_dec;
                    w_count_next  = r_count - CNT_W'(1);
                end else begin
                    w_pc_next  = w_seq;
                    w_unf_next = 1'b1;
                end
            end else if (hit) begin
                w_load_target = 1'b1;
            end else begin
                w_pc_next = w_seq;
            end
        end
        if (w_load_target) begin
            w_pc_next = w_target;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc    <= RESET_VEC;
            r_top   <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_pc    <= w_pc_next;
            r_top   <= w_top_next;
            r_count <= w_count_next;
            r_ovf   <= w_ovf_next;
            r_unf   <= w_unf_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && w_push) begin
            r_stack[w_ptr_inc] <= w_seq;
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    logic r_misalign;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= w_load_target && w_target_misaligned;
        end
    end

    assign misalign = r_misalign;
`else
    logic w_unused;
    assign w_unused = w_target_misaligned;
`endif

    assign result    = r_pc;
    assign ras_empty = w_empty;
    assign ras_full  = w_full;
    assign ras_ovf   = r_ovf;
    assign ras_unf   = r_unf;

endmodule

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit at default parameters.
// Honours PC_ALIGN_CHECK_EN to select the expected alignment behaviour.
module tb_pc_unit;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        hit;
    logic [31:0] data;
    logic        call;
    logic        ret;
    logic [31:0] result;
    logic        ras_empty;
    logic        ras_full;
    logic        ras_ovf;
    logic        ras_unf;
`ifdef PC_ALIGN_CHECK_EN
    logic        misalign;
`endif

    int checks;
    int errors;

    pc_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .stall     (stall),
        .hit       (hit),
        .data      (data),
        .call      (call),
        .ret       (ret),
        .result    (result),
        .ras_empty (ras_empty),
        .ras_full  (ras_full),
        .ras_ovf   (ras_ovf),
`ifdef PC_ALIGN_CHECK_EN
        .ras_unf   (ras_unf),
        .misalign  (misalign)
`else
        .ras_unf   (ras_unf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        stall = 1'b0; hit = 1'b0; call = 1'b0; ret = 1'b0; data = '0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        tick();
        tick();
        checks++; if (result !== 32'd0) begin errors++; $display("[TB] FAIL reset_result got %0d want 0", result); end
        checks++; if (ras_empty !== 1'b1 || ras_full !== 1'b0) begin errors++; $display("[TB] FAIL reset_flags got empty=%b full=%b want 1 0", ras_empty, ras_full); end
        checks++; if (ras_ovf !== 1'b0 || ras_unf !== 1'b0) begin errors++; $display("[TB] FAIL reset_pulses got ovf=%b unf=%b want 0 0", ras_ovf, ras_unf); end
        rst_n = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++; if (result !== 32'(4 * i)) begin errors++; $display("[TB] FAIL increment_%0d got %0d want %0d", i, result, 4 * i); end
        end
        checks++; if (ras_empty !== 1'b1) begin errors++; $display("[TB] FAIL increment_empty got %b want 1", ras_empty); end
    endtask

    task automatic test_redirect_stall();
        hit = 1'b1; data = 32'd40;
        tick();
        checks++; if (result !== 32'd40) begin errors++; $display("[TB] FAIL redirect got %0d want 40", result); end
        idle();
        tick();
        checks++; if (result !== 32'd44) begin errors++; $display("[TB] FAIL after_redirect got %0d want 44", result); end
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (result !== 32'd44) begin errors++; $display("[TB] FAIL stall_%0d got %0d want 44", i, result); end
        end
        hit = 1'b1; data = 32'd100;
        tick();
        checks++; if (result !== 32'd44) begin errors++; $display("[TB] FAIL stall_hit got %0d want 44", result); end
        idle();
    endtask

    task automatic test_call_return();
        do_reset();
        tick();
        tick();
        checks++; if (result !== 32'd8) begin errors++; $display("[TB] FAIL pre_call got %0d want 8", result); end
        call = 1'b1; data = 32'd200;
        tick();
        checks++; if (result !== 32'd200 || ras_empty !== 1'b0) begin errors++; $display("[TB] FAIL call got %0d empty=%b want 200 0", result, ras_empty); end
        idle();
        tick();
        tick();
        checks++; if (result !== 32'd208) begin errors++; $display("[TB] FAIL in_callee got %0d want 208", result); end
        ret = 1'b1;
        tick();
        checks++; if (result !== 32'd12 || ras_empty !== 1'b1) begin errors++; $display("[TB] FAIL return got %0d empty=%b want 12 1", result, ras_empty); end
        idle();
    endtask

    task automatic test_overflow_underflow();
        logic [31:0] exp_ret [4];
        exp_ret = '{32'd404, 32'd304, 32'd204, 32'd104};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            call = 1'b1; data = 32'(100 * (i + 1));
            tick();
            checks++; if (result !== 32'(100 * (i + 1))) begin errors++; $display("[TB] FAIL ovf_call_%0d got %0d want %0d", i, result, 100 * (i + 1)); end
            if (i == 3) begin
                checks++; if (ras_full !== 1'b1 || ras_ovf !== 1'b0) begin errors++; $display("[TB] FAIL fourth_call got full=%b ovf=%b want 1 0", ras_full, ras_ovf); end
            end
        end
        checks++; if (ras_ovf !== 1'b1 || ras_full !== 1'b1) begin errors++; $display("[TB] FAIL overflow got ovf=%b full=%b want 1 1", ras_ovf, ras_full); end
        call = 1'b0; ret = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (result !== exp_ret[i]) begin errors++; $display("[TB] FAIL pop_%0d got %0d want %0d", i, result, exp_ret[i]); end
            if (i == 0) begin
                checks++; if (ras_ovf !== 1'b0) begin errors++; $display("[TB] FAIL ovf_pulse_width got %b want 0", ras_ovf); end
            end
        end
        checks++; if (ras_empty !== 1'b1 || ras_unf !== 1'b0) begin errors++; $display("[TB] FAIL drained got empty=%b unf=%b want 1 0", ras_empty, ras_unf); end
        tick();
        checks++; if (result !== 32'd108 || ras_unf !== 1'b1) begin errors++; $display("[TB] FAIL underflow got %0d unf=%b want 108 1", result, ras_unf); end
        idle();
        tick();
        checks++; if (result !== 32'd112 || ras_unf !== 1'b0) begin errors++; $display("[TB] FAIL unf_pulse_width got %0d unf=%b want 112 0", result, ras_unf); end
    endtask

    task automatic test_wrap_reset();
        hit = 1'b1; data = 32'hFFFF_FFFC;
        tick();
        checks++; if (result !== 32'hFFFF_FFFC) begin errors++; $display("[TB] FAIL wrap_load got %h want fffffffc", result); end
        idle();
        tick();
        checks++; if (result !== 32'd0) begin errors++; $display("[TB] FAIL wrap got %h want 0", result); end
        call = 1'b1; data = 32'd50;
        tick();
        checks++; if (result !== 32'd50 || ras_empty !== 1'b0) begin errors++; $display("[TB] FAIL pre_reset_call got %0d empty=%b want 50 0", result, ras_empty); end
        call = 1'b0; ret = 1'b1; rst_n = 1'b0;
        tick();
        checks++; if (result !== 32'd0 || ras_empty !== 1'b1 || ras_unf !== 1'b0) begin errors++; $display("[TB] FAIL reset_over_ret got %0d empty=%b unf=%b want 0 1 0", result, ras_empty, ras_unf); end
        rst_n = 1'b1;
        idle();
    endtask

    task automatic test_back_to_back();
        do_reset();
        call = 1'b1; ret = 1'b1; data = 32'd300;
        tick();
        checks++; if (result !== 32'd300 || ras_empty !== 1'b0) begin errors++; $display("[TB] FAIL call_beats_ret got %0d empty=%b want 300 0", result, ras_empty); end
        call = 1'b0; ret = 1'b1; hit = 1'b1; data = 32'd900;
        tick();
        checks++; if (result !== 32'd4 || ras_empty !== 1'b1) begin errors++; $display("[TB] FAIL ret_beats_hit got %0d empty=%b want 4 1", result, ras_empty); end
        idle();
    endtask

    task automatic test_align();
        do_reset();
        hit = 1'b1; data = 32'd70;
        tick();
`ifdef PC_ALIGN_CHECK_EN
        checks++; if (result !== 32'd68 || misalign !== 1'b1) begin errors++; $display("[TB] FAIL align_70 got %0d misalign=%b want 68 1", result, misalign); end
        data = 32'd72;
        tick();
        checks++; if (result !== 32'd72 || misalign !== 1'b0) begin errors++; $display("[TB] FAIL align_72 got %0d misalign=%b want 72 0", result, misalign); end
`else
        checks++; if (result !== 32'd70) begin errors++; $display("[TB] FAIL unaligned_70 got %0d want 70", result); end
`endif
        idle();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        idle();
        test_reset();
        test_redirect_stall();
        test_call_return();
        test_overflow_underflow();
        test_wrap_reset();
        test_back_to_back();
        test_align();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
